// File: rtl/sensor_cmd_tx.sv
// UART 8N1 transmitter that sends fixed 5-byte sensor configuration frames
// (FF AA reg data_lo data_hi) onto the sensor's wireless_rx line.
module sensor_cmd_tx #(
    parameter int CLKS_PER_BIT = 96,
    parameter int GAP_BITS     = 10
) (
    input  logic        clk_uart,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_reg,
    input  logic [15:0] cmd_data,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0]        LAST_BYTE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [2:0]          byte_q, byte_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [39:0]         shift_q, shift_d;
    logic [7:0]          cur_byte_d;
    logic                baud_end;
    logic                tx_d, ready_d, busy_d, done_d;

    assign baud_end   = (baud_q == BAUD_LAST);
    assign cur_byte_d = shift_d[7:0];
    assign fsm_state  = state_q;

    // Handshake: a frame is accepted on any edge where cmd_valid && cmd_ready;
    // cmd_ready is high exactly while the FSM sits in IDLE (including the done cycle).
    always_ff @(posedge clk_uart) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            gap_q     <= '0;
            shift_q   <= '0;
            tx        <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            tx        <= tx_d;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        shift_d = shift_q;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (cmd_valid) begin
                    shift_d = {cmd_data[15:8], cmd_data[7:0], cmd_reg, 8'hAA, 8'hFF};
                    byte_d  = '0;
                    bit_d   = '0;
                    gap_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Bytes follow each other with no idle; the gap only trails the frame.
                if (baud_end) begin
                    if (byte_q < LAST_BYTE) begin
                        byte_d  = byte_q + 3'd1;
                        shift_d = {8'h00, shift_q[39:8]};
                        state_d = S_START;
                    end else if (GAP_BITS == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (baud_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q != S_IDLE) && (state_d == S_IDLE);
    end

endmodule
